// File: rtl/ps2_zx_keyboard_pkg.sv
// Shared definitions for the PS/2 to ZX Spectrum keyboard front end:
// scancode constants, receiver states, key-flag bundle and the
// set-2 scancode to matrix position lookup.
package zx_kbd_pkg;

    // Prefix and protocol bytes
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_OVR0   = 8'h00;
    localparam logic [7:0] SC_OVR1   = 8'hFF;

    // Hotkeys, modifiers and composite sources
    localparam logic [7:0] SC_F1     = 8'h05;
    localparam logic [7:0] SC_F11    = 8'h78;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_DEL    = 8'h71;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_ESC    = 8'h76;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_UP     = 8'h75;

    // Flat matrix indices (row*5 + col) of keys driven by composite flags
    localparam int POS_CAPS  = 0;   // r0c0
    localparam int POS_5     = 19;  // r3c4
    localparam int POS_0     = 20;  // r4c0
    localparam int POS_8     = 22;  // r4c2
    localparam int POS_7     = 23;  // r4c3
    localparam int POS_6     = 24;  // r4c4
    localparam int POS_SPACE = 35;  // r7c0
    localparam int POS_SYM   = 36;  // r7c1

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic [2:0] row;
        logic [2:0] col;
        logic       valid;
    } key_pos_t;

    // Keys with more than one source are held as separate flags so that
    // releasing one source never clears a target another source asserts.
    typedef struct packed {
        logic lshift;
        logic rshift;
        logic ctrl_l;
        logic ctrl_r;
        logic alt_l;
        logic alt_r;
        logic del;
        logic bksp;
        logic esc;
        logic left;
        logic right;
        logic up;
        logic down;
        logic f1;
        logic f11;
    } key_flags_t;

    // Plain (non-extended) set-2 codes that map onto exactly one matrix key
    function automatic key_pos_t sc2pos(input logic [7:0] sc);
        key_pos_t p;
        p = '0;
        case (sc)
            8'h1A: p = {3'd0, 3'd1, 1'b1};  // Z
            8'h22: p = {3'd0, 3'd2, 1'b1};  // X
            8'h21: p = {3'd0, 3'd3, 1'b1};  // C
            8'h2A: p = {3'd0, 3'd4, 1'b1};  // V
            8'h1C: p = {3'd1, 3'd0, 1'b1};  // A
            8'h1B: p = {3'd1, 3'd1, 1'b1};  // S
            8'h23: p = {3'd1, 3'd2, 1'b1};  // D
            8'h2B: p = {3'd1, 3'd3, 1'b1};  // F
            8'h34: p = {3'd1, 3'd4, 1'b1};  // G
            8'h15: p = {3'd2, 3'd0, 1'b1};  // Q
            8'h1D: p = {3'd2, 3'd1, 1'b1};  // W
            8'h24: p = {3'd2, 3'd2, 1'b1};  // E
            8'h2D: p = {3'd2, 3'd3, 1'b1};  // R
            8'h2C: p = {3'd2, 3'd4, 1'b1};  // T
            8'h16: p = {3'd3, 3'd0, 1'b1};  // 1
            8'h1E: p = {3'd3, 3'd1, 1'b1};  // 2
            8'h26: p = {3'd3, 3'd2, 1'b1};  // 3
            8'h25: p = {3'd3, 3'd3, 1'b1};  // 4
            8'h2E: p = {3'd3, 3'd4, 1'b1};  // 5
            8'h45: p = {3'd4, 3'd0, 1'b1};  // 0
            8'h46: p = {3'd4, 3'd1, 1'b1};  // 9
            8'h3E: p = {3'd4, 3'd2, 1'b1};  // 8
            8'h3D: p = {3'd4, 3'd3, 1'b1};  // 7
            8'h36: p = {3'd4, 3'd4, 1'b1};  // 6
            8'h4D: p = {3'd5, 3'd0, 1'b1};  // P
            8'h44: p = {3'd5, 3'd1, 1'b1};  // O
            8'h43: p = {3'd5, 3'd2, 1'b1};  // I
            8'h3C: p = {3'd5, 3'd3, 1'b1};  // U
            8'h35: p = {3'd5, 3'd4, 1'b1};  // Y
            8'h5A: p = {3'd6, 3'd0, 1'b1};  // Enter
            8'h4B: p = {3'd6, 3'd1, 1'b1};  // L
            8'h42: p = {3'd6, 3'd2, 1'b1};  // K
            8'h3B: p = {3'd6, 3'd3, 1'b1};  // J
            8'h33: p = {3'd6, 3'd4, 1'b1};  // H
            8'h29: p = {3'd7, 3'd0, 1'b1};  // Space
            8'h3A: p = {3'd7, 3'd2, 1'b1};  // M
            8'h31: p = {3'd7, 3'd3, 1'b1};  // N
            8'h32: p = {3'd7, 3'd4, 1'b1};  // B
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/ps2_zx_keyboard_if.sv
// ULA-side bus of the keyboard: port-#FE address in, column data and
// hotkey / reset-request levels out.
interface zx_kbd_if;
    logic [15:0] A;
    logic [4:0]  KEYB;
    logic        F11;
    logic        F1;
    logic        warm_reset;
    logic        cold_reset;

    modport master (output A, input KEYB, F11, F1, warm_reset, cold_reset);
    modport slave  (input A, output KEYB, F11, F1, warm_reset, cold_reset);
endinterface

// File: rtl/ps2_zx_keyboard_rx.sv
// PS/2 frame receiver: synchronises the raw lines, debounces PS2_CLK,
// collects start/8 data/parity/stop and pulses valid for one cycle
// after a frame with odd parity and a high stop bit.
module ps2_rx
    import zx_kbd_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 2800
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] byte_o,
    output logic       valid_o
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          filt_q;
    logic [FW-1:0] fcnt_q;
    logic          fall;
    logic          dat;

    rx_state_t     state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_q, to_d;
    logic          vld_q, vld_d;

    // Two-flop synchronisers; idle level of both lines is high
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive opposite samples
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
        end else if (clk_sync_q[1] == filt_q) begin
            fcnt_q <= '0;
        end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
            filt_q <= clk_sync_q[1];
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_q + 1'b1;
        end
    end

    // The cycle the filtered clock goes low is the bit sample point
    assign fall = filt_q & ~clk_sync_q[1] & (fcnt_q == FW'(FILTER_LEN - 1));
    assign dat  = dat_sync_q[1];

    // Frame FSM next state, shift register and inter-bit timeout
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        vld_d    = 1'b0;
        to_d     = (state_q == RX_IDLE || fall) ? '0 : to_q + 1'b1;
        case (state_q)
            RX_IDLE: begin
                if (fall && !dat) begin
                    state_d  = RX_DATA;
                    bitcnt_d = 3'd0;
                end
            end
            RX_DATA: begin
                if (fall) begin
                    shreg_d  = {dat, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = RX_PARITY;
                end
            end
            RX_PARITY: begin
                if (fall) begin
                    par_d   = dat;
                    state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (fall) begin
                    state_d = RX_IDLE;
                    vld_d   = dat & (^{shreg_q, par_q});
                end
            end
            default: state_d = RX_IDLE;
        endcase
        if (state_q != RX_IDLE && !fall && to_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = RX_IDLE;
        end
    end

    // Control state of the receiver
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= RX_IDLE;
            bitcnt_q <= '0;
            to_q     <= '0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            to_q     <= to_d;
            vld_q    <= vld_d;
        end
    end

    // Received data bits; qualified by valid so no reset needed
    always_ff @(posedge clk_i) begin
        shreg_q <= shreg_d;
        par_q   <= par_d;
    end

    assign byte_o  = shreg_q;
    assign valid_o = vld_q;

endmodule

// File: rtl/ps2_zx_keyboard.sv
// PS/2 keyboard to ZX Spectrum 8x5 matrix: decodes set-2 make/break
// codes, keeps the matrix and composite-key flags, and serves the
// active-low column read for the half-rows selected by A[15:8].
module ps2_zx_keyboard
    import zx_kbd_pkg::*;
#(
    parameter int CLK_HZ     = 14_000_000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 200
) (
    input  logic     CLK,
    input  logic     RESET,
    input  logic     PS2_CLK,
    input  logic     PS2_DAT,
    zx_kbd_if.slave  kb
);

    localparam int TIMEOUT_CYC = int'(64'(TIMEOUT_US) * 64'(CLK_HZ) / 64'd1_000_000);

    logic [7:0]  rx_byte;
    logic        rx_vld;

    logic [39:0] base_q, base_d;
    key_flags_t  flg_q, flg_d;
    logic        ext_q, ext_d;
    logic        brk_q, brk_d;
    logic [39:0] eff;
    logic [4:0]  keyb_q, keyb_d;
    logic        warm_q, cold_q;
    key_pos_t    pos;
    logic [5:0]  idx;
    logic        mk;
    logic        unused_a;

    assign unused_a = ^kb.A[7:0];

    ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk_i    (CLK),
        .rst_i    (RESET),
        .ps2_clk_i(PS2_CLK),
        .ps2_dat_i(PS2_DAT),
        .byte_o   (rx_byte),
        .valid_o  (rx_vld)
    );

    // Prefix tracking and make/break decode into matrix and flags
    always_comb begin
        base_d = base_q;
        flg_d  = flg_q;
        ext_d  = ext_q;
        brk_d  = brk_q;
        pos    = sc2pos(rx_byte);
        idx    = 6'(pos.row) * 6'd5 + 6'(pos.col);
        mk     = ~brk_q;
        if (rx_vld) begin
            if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk_d = 1'b1;
            end else if (rx_byte == SC_BAT || rx_byte == SC_ACK || rx_byte == SC_RESEND) begin
                // keyboard protocol replies carry no key information
            end else if (rx_byte == SC_OVR0 || rx_byte == SC_OVR1) begin
                base_d = '0;
                flg_d  = '0;
                ext_d  = 1'b0;
                brk_d  = 1'b0;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (ext_q) begin
                    case (rx_byte)
                        SC_CTRL:  flg_d.ctrl_r = mk;
                        SC_ALT:   flg_d.alt_r  = mk;
                        SC_DEL:   flg_d.del    = mk;
                        SC_LEFT:  flg_d.left   = mk;
                        SC_RIGHT: flg_d.right  = mk;
                        SC_DOWN:  flg_d.down   = mk;
                        SC_UP:    flg_d.up     = mk;
                        default:  ;
                    endcase
                end else begin
                    case (rx_byte)
                        SC_LSHIFT: flg_d.lshift = mk;
                        SC_RSHIFT: flg_d.rshift = mk;
                        SC_CTRL:   flg_d.ctrl_l = mk;
                        SC_ALT:    flg_d.alt_l  = mk;
                        SC_BKSP:   flg_d.bksp   = mk;
                        SC_ESC:    flg_d.esc    = mk;
                        SC_F1:     flg_d.f1     = mk;
                        SC_F11:    flg_d.f11    = mk;
                        default:   if (pos.valid) base_d[idx] = mk;
                    endcase
                end
            end
        end
    end

    // Effective matrix: direct keys OR every flag that targets a position
    always_comb begin
        eff            = base_q;
        eff[POS_CAPS]  = base_q[POS_CAPS] | flg_q.lshift | flg_q.rshift | flg_q.bksp
                       | flg_q.esc | flg_q.left | flg_q.right | flg_q.up | flg_q.down;
        eff[POS_0]     = base_q[POS_0] | flg_q.bksp;
        eff[POS_SPACE] = base_q[POS_SPACE] | flg_q.esc;
        eff[POS_SYM]   = base_q[POS_SYM] | flg_q.ctrl_l | flg_q.ctrl_r;
        eff[POS_5]     = base_q[POS_5] | flg_q.left;
        eff[POS_8]     = base_q[POS_8] | flg_q.right;
        eff[POS_6]     = base_q[POS_6] | flg_q.down;
        eff[POS_7]     = base_q[POS_7] | flg_q.up;
    end

    // Column read: a column goes low if any selected row has it pressed
    always_comb begin
        keyb_d = 5'h1F;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (eff[r*5 + c] && !kb.A[8 + r]) keyb_d[c] = 1'b0;
            end
        end
    end

    // Key state, prefixes and registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            base_q <= '0;
            flg_q  <= '0;
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            keyb_q <= 5'h1F;
            warm_q <= 1'b0;
            cold_q <= 1'b0;
        end else begin
            base_q <= base_d;
            flg_q  <= flg_d;
            ext_q  <= ext_d;
            brk_q  <= brk_d;
            keyb_q <= keyb_d;
            warm_q <= (flg_q.ctrl_l | flg_q.ctrl_r) & (flg_q.alt_l | flg_q.alt_r) & flg_q.del;
            cold_q <= (flg_q.ctrl_l | flg_q.ctrl_r) & (flg_q.alt_l | flg_q.alt_r) & flg_q.bksp;
        end
    end

    assign kb.KEYB       = keyb_q;
    assign kb.F1         = flg_q.f1;
    assign kb.F11        = flg_q.f11;
    assign kb.warm_reset = warm_q;
    assign kb.cold_reset = cold_q;

endmodule

// File: tb/tb_ps2_zx_keyboard.sv
// Directed bench for ps2_zx_keyboard: PS/2 frames are bit-banged at
// 40 CLK per bit and outputs are compared with hand-derived values.
module tb_ps2_zx_keyboard;
    import zx_kbd_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;
    int   checks = 0;
    int   errors = 0;

    zx_kbd_if kbif ();

    ps2_zx_keyboard dut (
        .CLK    (clk),
        .RESET  (rst),
        .PS2_CLK(ps2_clk),
        .PS2_DAT(ps2_dat),
        .kb     (kbif)
    );

    always #35 clk = ~clk;

    initial begin
        #7000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        tick(10);
        ps2_clk = 1'b0;
        tick(20);
        ps2_clk = 1'b1;
        tick(10);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
        tick(30);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0);
    endtask

    task automatic set_a(input logic [15:0] a);
        kbif.A = a;
        tick(2);
    endtask

    task automatic test_reset();
        kbif.A = 16'h00FE;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        checks++; if (kbif.KEYB !== 5'h1F) begin errors++; $display("FAIL reset_keyb got %h want 1f", kbif.KEYB); end
        checks++; if (kbif.F11 !== 1'b0) begin errors++; $display("FAIL reset_f11 got %b want 0", kbif.F11); end
        checks++; if (kbif.F1 !== 1'b0) begin errors++; $display("FAIL reset_f1 got %b want 0", kbif.F1); end
        checks++; if (kbif.warm_reset !== 1'b0) begin errors++; $display("FAIL reset_warm got %b want 0", kbif.warm_reset); end
        checks++; if (kbif.cold_reset !== 1'b0) begin errors++; $display("FAIL reset_cold got %b want 0", kbif.cold_reset); end
    endtask

    task automatic test_make_break();
        send_byte(8'h1C);
        set_a(16'hFDFE);
        checks++; if (kbif.KEYB !== 5'h1E) begin errors++; $display("FAIL make_a_row1 got %h want 1e", kbif.KEYB); end
        set_a(16'hFEFE);
        checks++; if (kbif.KEYB !== 5'h1F) begin errors++; $display("FAIL make_a_row0 got %h want 1f", kbif.KEYB); end
        set_a(16'hFFFE);
        checks++; if (kbif.KEYB !== 5'h1F) begin errors++; $display("FAIL make_a_norow got %h want 1f", kbif.KEYB); end
        send_byte(8'h1C);
        send_byte(8'h1A);
        set_a(16'hFCFE);
        checks++; if (kbif.KEYB !== 5'h1C) begin errors++; $display("FAIL two_rows got %h want 1c", kbif.KEYB); end
        send_byte(8'hF0);
        send_byte(8'h1C);
        set_a(16'hFDFE);
        checks++; if (kbif.KEYB !== 5'h1F) begin errors++; $display("FAIL break_a got %h want 1f", kbif.KEYB); end
        send_byte(8'hF0);
        send_byte(8'h1A);
        set_a(16'hFCFE);
        checks++; if (kbif.KEYB !== 5'h1F) begin errors++; $display("FAIL break_z got %h want 1f", kbif.KEYB); end
    endtask

    task automatic test_parity();
        set_a(16'hFDFE);
        send_frame(8'h1C, 1'b1);
        tick(2);
        checks++; if (kbif.KEYB !== 5'h1F) begin errors++; $display("FAIL bad_parity got %h want 1f", kbif.KEYB); end
        send_byte(8'h1C);
        tick(2);
        checks++; if (kbif.KEYB !== 5'h1E) begin errors++; $display("FAIL after_bad_parity got %h want 1e", kbif.KEYB); end
        send_byte(8'hF0);
        send_byte(8'h1C);
    endtask

    task automatic test_composite();
        send_byte(8'h66);
        send_byte(8'h12);
        set_a(16'hEFFE);
        checks++; if (kbif.KEYB !== 5'h1E) begin errors++; $display("FAIL bksp_zero got %h want 1e", kbif.KEYB); end
        send_byte(8'hF0);
        send_byte(8'h66);
        set_a(16'hFEFE);
        checks++; if (kbif.KEYB !== 5'h1E) begin errors++; $display("FAIL caps_kept got %h want 1e", kbif.KEYB); end
        set_a(16'hEFFE);
        checks++; if (kbif.KEYB !== 5'h1F) begin errors++; $display("FAIL zero_released got %h want 1f", kbif.KEYB); end
        send_byte(8'hF0);
        send_byte(8'h12);
        set_a(16'hFEFE);
        checks++; if (kbif.KEYB !== 5'h1F) begin errors++; $display("FAIL caps_released got %h want 1f", kbif.KEYB); end
    endtask

    task automatic test_hotkeys();
        send_byte(8'h14);
        send_byte(8'h11);
        send_byte(8'hE0);
        send_byte(8'h71);
        checks++; if (kbif.warm_reset !== 1'b1) begin errors++; $display("FAIL warm_set got %b want 1", kbif.warm_reset); end
        set_a(16'h7FFE);
        checks++; if (kbif.KEYB !== 5'h1D) begin errors++; $display("FAIL ctrl_sym got %h want 1d", kbif.KEYB); end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h71);
        checks++; if (kbif.warm_reset !== 1'b0) begin errors++; $display("FAIL warm_clear got %b want 0", kbif.warm_reset); end
        send_byte(8'h66);
        checks++; if (kbif.cold_reset !== 1'b1) begin errors++; $display("FAIL cold_set got %b want 1", kbif.cold_reset); end
        send_byte(8'h78);
        checks++; if (kbif.F11 !== 1'b1) begin errors++; $display("FAIL f11_set got %b want 1", kbif.F11); end
        send_byte(8'h05);
        checks++; if (kbif.F1 !== 1'b1) begin errors++; $display("FAIL f1_set got %b want 1", kbif.F1); end
        send_byte(8'hF0);
        send_byte(8'h78);
        checks++; if (kbif.F11 !== 1'b0) begin errors++; $display("FAIL f11_clear got %b want 0", kbif.F11); end
        send_byte(8'hAA);
        checks++; if (kbif.F1 !== 1'b1) begin errors++; $display("FAIL aa_ignored got %b want 1", kbif.F1); end
        send_byte(8'h00);
        checks++; if (kbif.cold_reset !== 1'b0) begin errors++; $display("FAIL overrun_cold got %b want 0", kbif.cold_reset); end
        checks++; if (kbif.F1 !== 1'b0) begin errors++; $display("FAIL overrun_f1 got %b want 0", kbif.F1); end
        set_a(16'h00FE);
        checks++; if (kbif.KEYB !== 5'h1F) begin errors++; $display("FAIL overrun_keyb got %h want 1f", kbif.KEYB); end
    endtask

    task automatic test_timeout();
        logic [7:0] part;
        part = 8'h3A;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(part[i]);
        ps2_dat = 1'b1;
        tick(3000);
        send_byte(8'h29);
        set_a(16'h7FFE);
        checks++; if (kbif.KEYB !== 5'h1E) begin errors++; $display("FAIL timeout_space got %h want 1e", kbif.KEYB); end
        set_a(16'h00FE);
        checks++; if (kbif.KEYB !== 5'h1E) begin errors++; $display("FAIL timeout_nojunk got %h want 1e", kbif.KEYB); end
        send_byte(8'hF0);
        send_byte(8'h29);
        checks++; if (kbif.KEYB !== 5'h1F) begin errors++; $display("FAIL space_release got %h want 1f", kbif.KEYB); end
    endtask

    task automatic test_glitch();
        ps2_dat = 1'b0;
        tick(5);
        ps2_clk = 1'b0;
        tick(4);
        ps2_clk = 1'b1;
        tick(5);
        ps2_dat = 1'b1;
        tick(20);
        send_byte(8'h1C);
        set_a(16'hFDFE);
        checks++; if (kbif.KEYB !== 5'h1E) begin errors++; $display("FAIL glitch_frame got %h want 1e", kbif.KEYB); end
        send_byte(8'hF0);
        send_byte(8'h1C);
        checks++; if (kbif.KEYB !== 5'h1F) begin errors++; $display("FAIL glitch_release got %h want 1f", kbif.KEYB); end
    endtask

    task automatic test_mid_reset();
        set_a(16'hFDFE);
        send_byte(8'h1C);
        send_byte(8'h05);
        checks++; if (kbif.KEYB !== 5'h1E) begin errors++; $display("FAIL pre_reset_keyb got %h want 1e", kbif.KEYB); end
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++; if (kbif.KEYB !== 5'h1F) begin errors++; $display("FAIL midreset_keyb got %h want 1f", kbif.KEYB); end
        checks++; if (kbif.F1 !== 1'b0) begin errors++; $display("FAIL midreset_f1 got %b want 0", kbif.F1); end
        checks++; if (kbif.F11 !== 1'b0 || kbif.warm_reset !== 1'b0 || kbif.cold_reset !== 1'b0) begin
            errors++; $display("FAIL midreset_levels got %b%b%b want 000", kbif.F11, kbif.warm_reset, kbif.cold_reset);
        end
        tick(20);
        send_byte(8'h1C);
        checks++; if (kbif.KEYB !== 5'h1E) begin errors++; $display("FAIL post_reset_frame got %h want 1e", kbif.KEYB); end
        send_byte(8'hF0);
        send_byte(8'h1C);
    endtask

    initial begin
        kbif.A = 16'hFFFE;
        test_reset();
        test_make_break();
        test_parity();
        test_composite();
        test_hotkeys();
        test_timeout();
        test_glitch();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
